// File: rtl/triangle_dispatch_queue.sv
// Walks faces, requests three shaded vertices per face, queues triangles in a FWFT FIFO and
// dispatches them valid/ready. Define TRI_BACKFACE_CULL_EN to drop clockwise/degenerate faces.
module triangle_dispatch_queue #(
  parameter int unsigned FACE_AW = 20,
  parameter int unsigned VERT_AW = 20,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned DEPTH_W = 21,
  parameter int unsigned COLOR_W = 24,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic                                        clk,
  input  logic                                        srst,
  input  logic                                        start,
  input  logic [FACE_AW:0]                            num_faces,
  output logic                                        face_rd,
  output logic [FACE_AW-1:0]                          face_addr,
  input  logic [VERT_AW-1:0]                          face_v1,
  input  logic [VERT_AW-1:0]                          face_v2,
  input  logic [VERT_AW-1:0]                          face_v3,
  output logic                                        vs_req,
  output logic [VERT_AW-1:0]                          vs_idx,
  input  logic                                        vs_ack,
  input  logic [COORD_W-1:0]                          vs_x,
  input  logic [COORD_W-1:0]                          vs_y,
  input  logic [DEPTH_W-1:0]                          vs_depth,
  input  logic [COLOR_W-1:0]                          vs_color,
  output logic                                        tri_valid,
  input  logic                                        tri_ready,
  output logic [3*(2*COORD_W+DEPTH_W+COLOR_W)-1:0]    tri_data,
  output logic                                        busy,
  output logic                                        done,
  output logic [FACE_AW:0]                            tri_count,
  output logic [FACE_AW:0]                            culled_count
);
  localparam int unsigned VW = 2 * COORD_W + DEPTH_W + COLOR_W;
  localparam int unsigned TW = 3 * VW;
  localparam int unsigned PW = $clog2(QDEPTH);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitF, StVreq, StPush, StDrain, StDone} state_e;

  state_e              state_q;
  logic [FACE_AW:0]    nfaces_q;
  logic [FACE_AW-1:0]  face_q;
  logic [VERT_AW-1:0]  vidx_q [3];
  logic [VW-1:0]       vert_q [3];
  logic [1:0]          k_q;
  logic [FACE_AW:0]    tri_cnt_q;

  logic [TW-1:0]       mem_q [QDEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PW:0]         cnt_q;

  logic full, empty, push, pop, cull, last_face, frame_start;

  assign full        = (cnt_q == (PW+1)'(QDEPTH));
  assign empty       = (cnt_q == '0);
  assign tri_valid   = !empty;
  assign tri_data    = empty ? '0 : mem_q[rd_ptr_q];
  assign pop         = tri_valid && tri_ready;
  // A full FIFO blocks the push even when the head pops in the same cycle.
  assign push        = (state_q == StPush) && !cull && !full;
  assign last_face   = ({1'b0, face_q} == nfaces_q - 1'b1);
  assign frame_start = (state_q == StIdle) && start;
  assign tri_count   = tri_cnt_q;

`ifdef TRI_BACKFACE_CULL_EN
  localparam int unsigned AW = 2 * COORD_W + 3;
  logic signed [AW-1:0] dx2, dy3, dx3, dy2, area;
  logic [FACE_AW:0]     culled_q;

  // Coordinates are zero-extended before differencing so the signed area cannot overflow.
  assign dx2  = AW'(vert_q[1][COORD_W-1:0]) - AW'(vert_q[0][COORD_W-1:0]);
  assign dx3  = AW'(vert_q[2][COORD_W-1:0]) - AW'(vert_q[0][COORD_W-1:0]);
  assign dy2  = AW'(vert_q[1][2*COORD_W-1:COORD_W]) - AW'(vert_q[0][2*COORD_W-1:COORD_W]);
  assign dy3  = AW'(vert_q[2][2*COORD_W-1:COORD_W]) - AW'(vert_q[0][2*COORD_W-1:COORD_W]);
  assign area = dx2 * dy3 - dx3 * dy2;
  assign cull = area[AW-1] || (area == '0);
  assign culled_count = culled_q;

  always_ff @(posedge clk) begin
    if (srst || frame_start) begin
      culled_q <= '0;
    end else if ((state_q == StPush) && cull) begin
      culled_q <= culled_q + 1'b1;
    end
  end
`else
  assign cull         = 1'b0;
  assign culled_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!push && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {vert_q[2], vert_q[1], vert_q[0]};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= StIdle;
      nfaces_q  <= '0;
      face_q    <= '0;
      k_q       <= '0;
      tri_cnt_q <= '0;
      face_rd   <= 1'b0;
      face_addr <= '0;
      vs_req    <= 1'b0;
      vs_idx    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      face_rd <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            nfaces_q  <= num_faces;
            face_q    <= '0;
            tri_cnt_q <= '0;
            busy      <= 1'b1;
            if (num_faces == '0) begin
              state_q <= StDone;
            end else begin
              state_q   <= StFetch;
              face_rd   <= 1'b1;
              face_addr <= '0;
            end
          end
        end
        StFetch: state_q <= StWaitF;
        StWaitF: begin
          vidx_q[0] <= face_v1;
          vidx_q[1] <= face_v2;
          vidx_q[2] <= face_v3;
          k_q       <= '0;
          vs_req    <= 1'b1;
          vs_idx    <= face_v1;
          state_q   <= StVreq;
        end
        StVreq: begin
          if (vs_req && vs_ack) begin
            vert_q[k_q] <= {vs_color, vs_depth, vs_y, vs_x};
            vs_req      <= 1'b0;
            if (k_q == 2'd2) begin
              state_q <= StPush;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end else if (!vs_req) begin
            // One idle cycle after each ack, then request the next vertex.
            vs_req <= 1'b1;
            vs_idx <= vidx_q[k_q];
          end
        end
        StPush: begin
          if (cull || !full) begin
            if (!cull) tri_cnt_q <= tri_cnt_q + 1'b1;
            if (last_face) begin
              state_q <= StDrain;
            end else begin
              face_q    <= face_q + 1'b1;
              face_addr <= face_q + 1'b1;
              face_rd   <= 1'b1;
              state_q   <= StFetch;
            end
          end
        end
        StDrain: if (empty) state_q <= StDone;
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_dispatch_queue.sv
// Randomised bench for triangle_dispatch_queue against a face-list reference model.
module tb_triangle_dispatch_queue;
  localparam int FACE_AW = 20;
  localparam int VERT_AW = 20;
  localparam int COORD_W = 12;
  localparam int DEPTH_W = 21;
  localparam int COLOR_W = 24;
  localparam int QDEPTH  = 4;
  localparam int VW = 2 * COORD_W + DEPTH_W + COLOR_W;
  localparam int TW = 3 * VW;
`ifdef TRI_BACKFACE_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif

  typedef logic [255:0] w_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic start = 1'b0;
  logic [FACE_AW:0] num_faces = '0;
  logic face_rd;
  logic [FACE_AW-1:0] face_addr;
  logic [VERT_AW-1:0] face_v1, face_v2, face_v3;
  logic vs_req;
  logic [VERT_AW-1:0] vs_idx;
  logic vs_ack;
  logic [COORD_W-1:0] vs_x, vs_y;
  logic [DEPTH_W-1:0] vs_depth;
  logic [COLOR_W-1:0] vs_color;
  logic tri_valid;
  logic tri_ready;
  logic [TW-1:0] tri_data;
  logic busy, done;
  logic [FACE_AW:0] tri_count, culled_count;

  triangle_dispatch_queue #(
    .FACE_AW(FACE_AW), .VERT_AW(VERT_AW), .COORD_W(COORD_W),
    .DEPTH_W(DEPTH_W), .COLOR_W(COLOR_W), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .srst(srst), .start(start), .num_faces(num_faces),
    .face_rd(face_rd), .face_addr(face_addr),
    .face_v1(face_v1), .face_v2(face_v2), .face_v3(face_v3),
    .vs_req(vs_req), .vs_idx(vs_idx), .vs_ack(vs_ack),
    .vs_x(vs_x), .vs_y(vs_y), .vs_depth(vs_depth), .vs_color(vs_color),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_data(tri_data),
    .busy(busy), .done(done), .tri_count(tri_count), .culled_count(culled_count)
  );

  always #5 clk = ~clk;

  // Scene: face list and per-vertex screen positions (indices 50..54 reserved for culling cases).
  logic [VERT_AW-1:0] fa1 [64], fa2 [64], fa3 [64];
  logic [COORD_W-1:0] shx [64], shy [64];

  int n_tests = 0;
  int n_fail  = 0;

  int ready_mode = 1;
  bit stab_en = 1'b0;
  bit hold_en = 1'b0;
  bit sh_rand = 1'b0;
  int sh_delay = 1;
  int stray_req = 0;
  int stray_done = 0;
  int stab_viol = 0;
  int hold_viol = 0;
  logic [TW-1:0] got_q [$];
  logic [VERT_AW-1:0] idx_log [$];

  int n_rd = 0, n_ack = 0, n_done = 0, n_reqcyc = 0;

  logic [TW-1:0] exp_tri [$];
  logic [VERT_AW-1:0] exp_idx [$];
  int exp_cull;
  int rd0, ack0, dn0, got0, idx0, req0, hv0, sv0;

  task automatic check(input string tag, input w_t got, input w_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] shade(input logic [VERT_AW-1:0] idx);
    logic [COLOR_W-1:0] c;
    logic [DEPTH_W-1:0] d;
    c = COLOR_W'(idx * 7) ^ 24'hA5C3E1;
    d = DEPTH_W'(idx * 13 + 5);
    return {c, d, shy[idx[5:0]], shx[idx[5:0]]};
  endfunction

  function automatic longint tri_area(input int a, input int b, input int c);
    longint x1, y1, x2, y2, x3, y3;
    x1 = longint'(shx[a]); y1 = longint'(shy[a]);
    x2 = longint'(shx[b]); y2 = longint'(shy[b]);
    x3 = longint'(shx[c]); y3 = longint'(shy[c]);
    return (x2 - x1) * (y3 - y1) - (x3 - x1) * (y2 - y1);
  endfunction

  function automatic int pick_delay();
    return sh_rand ? int'($urandom_range(0, 3)) : sh_delay;
  endfunction

  always @(posedge clk) begin
    if (face_rd) n_rd <= n_rd + 1;
    if (vs_req && vs_ack) n_ack <= n_ack + 1;
    if (done) n_done <= n_done + 1;
    if (vs_req) n_reqcyc <= n_reqcyc + 1;
  end

  // Face SRAM: data valid only in the cycle after face_rd, junk otherwise.
  initial begin
    logic pend;
    logic [FACE_AW-1:0] a;
    pend = 1'b0;
    a = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        face_v1 = fa1[a[5:0]];
        face_v2 = fa2[a[5:0]];
        face_v3 = fa3[a[5:0]];
      end else begin
        face_v1 = VERT_AW'($urandom);
        face_v2 = VERT_AW'($urandom);
        face_v3 = VERT_AW'($urandom);
      end
      pend = face_rd;
      a = face_addr;
    end
  end

  // Vertex shader: acks after a chosen delay, junk data while not acking.
  initial begin
    int wait_cnt;
    logic prev_wait;
    logic [VERT_AW-1:0] prev_idx;
    wait_cnt = 0;
    prev_wait = 1'b0;
    prev_idx = '0;
    vs_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hold_en && prev_wait && (!vs_req || vs_idx != prev_idx)) hold_viol++;
      prev_wait = 1'b0;
      if (vs_ack) begin
        vs_ack = 1'b0;
        {vs_color, vs_depth, vs_y, vs_x} = VW'({$urandom, $urandom, $urandom});
        wait_cnt = pick_delay();
      end else if (stray_req != stray_done) begin
        vs_ack = 1'b1;
        {vs_color, vs_depth, vs_y, vs_x} = VW'({$urandom, $urandom, $urandom});
        stray_done++;
      end else if (vs_req) begin
        if (wait_cnt == 0) begin
          vs_ack = 1'b1;
          {vs_color, vs_depth, vs_y, vs_x} = shade(vs_idx);
          idx_log.push_back(vs_idx);
        end else begin
          wait_cnt--;
          prev_wait = 1'b1;
          prev_idx = vs_idx;
        end
      end else begin
        wait_cnt = pick_delay();
        {vs_color, vs_depth, vs_y, vs_x} = VW'({$urandom, $urandom, $urandom});
      end
    end
  end

  // Rasterizer sink: records every accepted triangle, watches head stability under backpressure.
  initial begin
    logic hold_prev;
    logic [TW-1:0] data_prev;
    hold_prev = 1'b0;
    data_prev = '0;
    tri_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stab_en && hold_prev && (!tri_valid || tri_data != data_prev)) stab_viol++;
      case (ready_mode)
        0:       tri_ready = 1'b0;
        1:       tri_ready = 1'b1;
        default: tri_ready = 1'($urandom_range(0, 1));
      endcase
      if (tri_valid && tri_ready) got_q.push_back(tri_data);
      hold_prev = tri_valid && !tri_ready;
      data_prev = tri_data;
    end
  end

  task automatic rand_faces(input int n);
    for (int i = 0; i < n; i++) begin
      fa1[i] = VERT_AW'($urandom_range(0, 49));
      fa2[i] = VERT_AW'($urandom_range(0, 49));
      fa3[i] = VERT_AW'($urandom_range(0, 49));
    end
  endtask

  task automatic prep(input int n);
    exp_tri.delete();
    exp_idx.delete();
    exp_cull = 0;
    for (int i = 0; i < n; i++) begin
      if (CULL && tri_area(int'(fa1[i]), int'(fa2[i]), int'(fa3[i])) <= 0) exp_cull++;
      else exp_tri.push_back({shade(fa3[i]), shade(fa2[i]), shade(fa1[i])});
      exp_idx.push_back(fa1[i]);
      exp_idx.push_back(fa2[i]);
      exp_idx.push_back(fa3[i]);
    end
    rd0 = n_rd; ack0 = n_ack; dn0 = n_done; req0 = n_reqcyc;
    got0 = got_q.size(); idx0 = idx_log.size(); hv0 = hold_viol; sv0 = stab_viol;
  endtask

  task automatic kick(input int n);
    @(negedge clk);
    num_faces = (FACE_AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int t;
    t = 0;
    while (n_done == dn0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, " done_seen"}, w_t'(n_done != dn0), w_t'(1));
    repeat (2) @(negedge clk);
    check({tag, " done_pulses"}, w_t'(n_done - dn0), w_t'(1));
    check({tag, " busy_after"}, w_t'(busy), w_t'(0));
    check({tag, " tri_count"}, w_t'(tri_count), w_t'(exp_tri.size()));
    check({tag, " culled_count"}, w_t'(culled_count), w_t'(exp_cull));
    check({tag, " rx_count"}, w_t'(got_q.size() - got0), w_t'(exp_tri.size()));
    for (int i = 0; i < exp_tri.size(); i++) begin
      if (got0 + i < got_q.size()) check({tag, " tri_data"}, w_t'(got_q[got0 + i]), w_t'(exp_tri[i]));
    end
    check({tag, " vs_count"}, w_t'(idx_log.size() - idx0), w_t'(exp_idx.size()));
    for (int i = 0; i < exp_idx.size(); i++) begin
      if (idx0 + i < idx_log.size()) check({tag, " vs_idx"}, w_t'(idx_log[idx0 + i]), w_t'(exp_idx[i]));
    end
    check({tag, " head_stable"}, w_t'(stab_viol - sv0), w_t'(0));
  endtask

  initial begin
    int t;
    for (int i = 0; i < 64; i++) begin
      shx[i] = COORD_W'($urandom);
      shy[i] = COORD_W'($urandom);
    end
    shx[50] = 12'd0;  shy[50] = 12'd0;
    shx[51] = 12'd10; shy[51] = 12'd0;
    shx[52] = 12'd0;  shy[52] = 12'd10;
    shx[53] = 12'd1;  shy[53] = 12'd1;
    shx[54] = 12'd2;  shy[54] = 12'd2;

    repeat (3) @(negedge clk);
    check("rst tri_valid", w_t'(tri_valid), w_t'(0));
    check("rst busy", w_t'(busy), w_t'(0));
    check("rst done", w_t'(done), w_t'(0));
    check("rst vs_req", w_t'(vs_req), w_t'(0));
    check("rst face_rd", w_t'(face_rd), w_t'(0));
    check("rst tri_count", w_t'(tri_count), w_t'(0));
    check("rst culled", w_t'(culled_count), w_t'(0));
    check("rst tri_data", w_t'(tri_data), w_t'(0));
    srst = 1'b0;
    @(negedge clk);

    // Single face, vertices 5,6,7, ack one cycle after each request.
    fa1[0] = 20'd5; fa2[0] = 20'd6; fa3[0] = 20'd7;
    prep(1);
    kick(1);
    finish_frame("t1");

    // Backpressure: FIFO fills, controller stalls in push, then drains in order.
    rand_faces(8);
    ready_mode = 0;
    stab_en = 1'b1;
    prep(8);
    kick(8);
    repeat (150) @(negedge clk);
    check("t2 stall face_reads", w_t'(n_rd - rd0), w_t'(5));
    check("t2 stall acks", w_t'(n_ack - ack0), w_t'(15));
    check("t2 stall tri_valid", w_t'(tri_valid), w_t'(1));
    check("t2 stall busy", w_t'(busy), w_t'(1));
    check("t2 stall no_pop", w_t'(got_q.size() - got0), w_t'(0));
    ready_mode = 1;
    finish_frame("t2");

    // Empty frame: done exactly two cycles after start.
    prep(0);
    kick(0);
    check("t3 done_early", w_t'(done), w_t'(0));
    check("t3 busy_mid", w_t'(busy), w_t'(1));
    @(negedge clk);
    check("t3 done_at_2", w_t'(done), w_t'(1));
    check("t3 busy_at_2", w_t'(busy), w_t'(0));
    finish_frame("t3");
    check("t3 no_face_rd", w_t'(n_rd - rd0), w_t'(0));

    // Stray ack in idle, slow shader, start while busy.
    stray_req++;
    repeat (4) @(negedge clk);
    check("t4 stray vs_req", w_t'(vs_req), w_t'(0));
    check("t4 stray busy", w_t'(busy), w_t'(0));
    check("t4 stray tri_valid", w_t'(tri_valid), w_t'(0));
    rand_faces(2);
    sh_delay = 10;
    hold_en = 1'b1;
    prep(2);
    kick(2);
    repeat (20) @(negedge clk);
    num_faces = 21'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_frame("t4");
    check("t4 req_cycles", w_t'(n_reqcyc - req0), w_t'(66));
    check("t4 req_hold", w_t'(hold_viol - hv0), w_t'(0));
    hold_en = 1'b0;
    sh_delay = 1;

    // Synchronous reset mid-request with two triangles queued, then a clean frame.
    stab_en = 1'b0;
    ready_mode = 0;
    rand_faces(8);
    prep(8);
    kick(8);
    t = 0;
    while (n_ack < ack0 + 7 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t5 reached_vreq", w_t'(n_ack >= ack0 + 7), w_t'(1));
    check("t5 queued_valid", w_t'(tri_valid), w_t'(1));
    srst = 1'b1;
    @(negedge clk);
    check("t5 rst tri_valid", w_t'(tri_valid), w_t'(0));
    check("t5 rst vs_req", w_t'(vs_req), w_t'(0));
    check("t5 rst busy", w_t'(busy), w_t'(0));
    check("t5 rst tri_count", w_t'(tri_count), w_t'(0));
    srst = 1'b0;
    ready_mode = 2;
    sh_rand = 1'b1;
    repeat (2) @(negedge clk);
    stab_en = 1'b1;
    rand_faces(6);
    prep(6);
    kick(6);
    finish_frame("t5");

    // Winding: CCW, CW and collinear faces.
    fa1[0] = 20'd50; fa2[0] = 20'd51; fa3[0] = 20'd52;
    fa1[1] = 20'd50; fa2[1] = 20'd52; fa3[1] = 20'd51;
    fa1[2] = 20'd50; fa2[2] = 20'd53; fa3[2] = 20'd54;
    prep(3);
    kick(3);
    finish_frame("t6");
    check("t6 tri_count_fixed", w_t'(tri_count), w_t'(CULL ? 1 : 3));
    check("t6 culled_fixed", w_t'(culled_count), w_t'(CULL ? 2 : 0));

    // Random frames with random shader latency and random backpressure.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 12));
      rand_faces(n);
      prep(n);
      kick(n);
      finish_frame("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
